// File: rtl/fetch_queue_pkg.sv
// Shared constants and types for the prefetching fetch queue.
// Default geometry; modules derive their own widths from their parameters.
package fetch_queue_pkg;

  localparam int DEF_DEPTH    = 4;
  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_INST_W   = 32;
  localparam int DEF_PC_STEP  = 4;
  localparam int DEF_RESET_PC = 0;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  localparam int PTR_W   = ptr_width(DEF_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = DEF_ADDR_W + DEF_INST_W;

  // Queue entry layout: next-sequential PC in the upper bits, instruction below.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: DEPTH x WIDTH registers,
// one synchronous write port and one asynchronous read port.
module fetch_queue_mem
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = ENTRY_W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // No reset: contents are only observed through valid occupancy.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Prefetching fetch unit: owns the PC, fetches one instruction per cycle into a
// circular queue, and presents the head. Optional bypass: FETCH_QUEUE_BYPASS_EN.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int                DEPTH    = DEF_DEPTH,
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INST_W   = DEF_INST_W,
  parameter int                PC_STEP  = DEF_PC_STEP,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   branch_taken,
  input  logic [ADDR_W-1:0]      branch_address,
  output logic [ADDR_W-1:0]      imem_addr,
  input  logic [INST_W-1:0]      imem_rdata,
  output logic [ADDR_W-1:0]      PC,
  output logic [INST_W-1:0]      Instruction,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_W + INST_W;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_inc;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     cnt_q;
  logic              q_valid;
  logic              full;
  logic              push;
  logic              pop;
  logic              advance;
  logic [EW-1:0]     head;
  logic [EW-1:0]     wr_entry;

  assign pc_inc    = pc_q + ADDR_W'(PC_STEP);
  assign imem_addr = pc_q;
  assign count     = cnt_q;
  assign q_valid   = (cnt_q != '0);
  assign full      = (cnt_q == CW'(DEPTH));
  assign wr_entry  = {pc_inc, imem_rdata};

  always_comb begin
    pop         = q_valid & ~freeze & ~branch_taken;
    push        = ~branch_taken & (~full | pop);
    advance     = push;
    valid       = q_valid;
    PC          = q_valid ? head[EW-1:INST_W] : '0;
    Instruction = q_valid ? head[INST_W-1:0]  : '0;
`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue: hand the word being fetched straight to the consumer.
    if (!q_valid && !branch_taken && !rst) begin
      valid       = 1'b1;
      PC          = pc_inc;
      Instruction = imem_rdata;
      if (!freeze) begin
        push    = 1'b0;
        advance = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else if (branch_taken) begin
      pc_q   <= branch_address;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (advance) pc_q   <= pc_inc;
      if (push)    wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with hand-computed expectations.
// Memory model returns 32'hE000_0000 | address.
module tb_fetch_queue;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam logic [31:0] TB_RESET_PC = 32'hFFFF_FFFC;
`else
  localparam logic [31:0] TB_RESET_PC = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic        valid;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign imem_rdata = 32'hE000_0000 | imem_addr;

  fetch_queue #(
    .DEPTH    (4),
    .ADDR_W   (32),
    .INST_W   (32),
    .PC_STEP  (4),
    .RESET_PC (TB_RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .branch_taken   (branch_taken),
    .branch_address (branch_address),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .PC             (PC),
    .Instruction    (Instruction),
    .valid          (valid),
    .count          (count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic frz);
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_address = '0;
    step();
    step();
    rst = 1'b0; freeze = frz;
    #1;
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_address = '0;
`ifdef FETCH_QUEUE_BYPASS_EN
    do_reset(1'b0);
    chk("byp_valid0", 64'(valid), 64'd1);
    chk("byp_pc_wrap", 64'(PC), 64'h0);
    chk("byp_inst0", 64'(Instruction), 64'hFFFF_FFFC);
    chk("byp_cnt0", 64'(count), 64'd0);
    step();
    chk("byp_imem1", 64'(imem_addr), 64'h0);
    chk("byp_cnt1", 64'(count), 64'd0);
    chk("byp_pc1", 64'(PC), 64'h4);
    chk("byp_inst1", 64'(Instruction), 64'hE000_0000);
    freeze = 1'b1;
    step();
    chk("byp_frz_cnt", 64'(count), 64'd1);
    chk("byp_frz_pc", 64'(PC), 64'h4);
    step();
    chk("byp_frz_cnt2", 64'(count), 64'd2);
    chk("byp_frz_hold", 64'(PC), 64'h4);
    freeze = 1'b0;
    step();
    chk("byp_pop_pc", 64'(PC), 64'h8);
    chk("byp_pop_cnt", 64'(count), 64'd2);
`else
    // Reset state and streaming throughput
    do_reset(1'b0);
    chk("rst_cnt", 64'(count), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_imem", 64'(imem_addr), 64'h0);
    chk("rst_pc_zero", 64'(PC), 64'h0);
    step();
    chk("s0_valid", 64'(valid), 64'd1);
    chk("s0_pc", 64'(PC), 64'h4);
    chk("s0_inst", 64'(Instruction), 64'hE000_0000);
    chk("s0_cnt", 64'(count), 64'd1);
    step();
    chk("s1_pc", 64'(PC), 64'h8);
    chk("s1_inst", 64'(Instruction), 64'hE000_0004);
    step();
    chk("s2_pc", 64'(PC), 64'hC);
    chk("s2_cnt", 64'(count), 64'd1);

    // Freeze fills the queue, then release drains in order
    do_reset(1'b1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("frz_cnt%0d", i), 64'(count), 64'(i < 4 ? i + 1 : 4));
      chk($sformatf("frz_head%0d", i), 64'(PC), 64'h4);
    end
    chk("frz_imem", 64'(imem_addr), 64'h10);
    freeze = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("drain_pc%0d", i), 64'(PC), 64'(8 + 4 * i));
      chk($sformatf("drain_cnt%0d", i), 64'(count), 64'd4);
    end

    // Branch with count=3
    do_reset(1'b1);
    step(); step(); step();
    chk("br_pre_cnt", 64'(count), 64'd3);
    freeze = 1'b0; branch_taken = 1'b1; branch_address = 32'h100;
    step();
    branch_taken = 1'b0;
    #1;
    chk("br_cnt", 64'(count), 64'd0);
    chk("br_valid", 64'(valid), 64'd0);
    chk("br_imem", 64'(imem_addr), 64'h100);
    step();
    chk("br_pc", 64'(PC), 64'h104);
    chk("br_inst", 64'(Instruction), 64'hE000_0100);

    // Branch together with freeze while full
    freeze = 1'b1;
    step(); step(); step();
    chk("brf_full", 64'(count), 64'd4);
    branch_taken = 1'b1; branch_address = 32'h200;
    step();
    branch_taken = 1'b0;
    #1;
    chk("brf_cnt", 64'(count), 64'd0);
    chk("brf_imem", 64'(imem_addr), 64'h200);

    // Reset while full and frozen, with a competing branch
    step(); step(); step(); step();
    chk("rstf_full", 64'(count), 64'd4);
    rst = 1'b1; branch_taken = 1'b1; branch_address = 32'h300;
    step();
    rst = 1'b0; branch_taken = 1'b0; freeze = 1'b0;
    #1;
    chk("rstf_cnt", 64'(count), 64'd0);
    chk("rstf_valid", 64'(valid), 64'd0);
    chk("rstf_imem", 64'(imem_addr), 64'h0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
